// File: rtl/alu_scheduler.sv
// Round-robin scheduler in front of a shared 4-op ALU (ADD/SUB/AND/XOR).
// Grants one requester, latches its operands, returns a tagged result.
module alu_scheduler #(
  parameter  int DATA_WIDTH = 4,
  parameter  int N_REQ      = 4,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] a_bus,
  input  logic [N_REQ*DATA_WIDTH-1:0] b_bus,
  input  logic [N_REQ*2-1:0]          op_bus,
  output logic [N_REQ-1:0]            gnt,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_WIDTH:0]         res_data,
  output logic                        res_zero,
  output logic [ID_W-1:0]             res_id
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       last_id_q, last_id_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic                  busy_q, busy_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH:0]   res_data_q, res_data_d;
  logic                  res_zero_q, res_zero_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;

  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       cand;
  logic [DATA_WIDTH:0]   alu_res;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_id_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Shared ALU on the latched operands; MSB is carry/borrow
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      2'b00: alu_res = {1'b0, a_q} + {1'b0, b_q};
      2'b01: alu_res = {1'b0, a_q} - {1'b0, b_q};
      2'b10: alu_res = {1'b0, a_q & b_q};
      2'b11: alu_res = {1'b0, a_q ^ b_q};
      default: alu_res = '0;
    endcase
  end

  // Sequencing: grant in IDLE, compute in EXEC, hold result in RESP
  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    gnt_d       = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_id_d    = res_id_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d       = EXEC;
          last_id_d     = win_id;
          id_d          = win_id;
          a_d           = a_bus[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
          b_d           = b_bus[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
          op_d          = op_bus[int'(win_id)*2 +: 2];
          gnt_d[win_id] = 1'b1;
        end
      end
      EXEC: begin
        state_d     = RESP;
        res_data_d  = alu_res;
        res_zero_d  = (alu_res == '0);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
      end
      RESP: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_id_q   <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_id_q    <= res_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed + random bench for alu_scheduler.
// Scoreboard queue holds expected results pushed at request time.
module tb_alu_scheduler;

  localparam int DW = 4;
  localparam int N  = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW:0]   data;
    logic          zero;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] a_bus;
  logic [N*DW-1:0] b_bus;
  logic [N*2-1:0]  op_bus;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            res_valid;
  logic            res_ready;
  logic [DW:0]     res_data;
  logic            res_zero;
  logic [1:0]      res_id;

  logic [DW-1:0]   ta  [N];
  logic [DW-1:0]   tbb [N];
  logic [1:0]      to  [N];
  logic [1:0]      last_id;
  exp_t            sb[$];
  int              tests = 0;
  int              fails = 0;

  alu_scheduler #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .op_bus    (op_bus),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] ref_alu(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic int model_win(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_id) + k) % N;
      if (mask[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      a_bus[i*DW +: DW] = ta[i];
      b_bus[i*DW +: DW] = tbb[i];
      op_bus[i*2 +: 2]  = to[i];
    end
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [1:0] op);
    ta[i]  = a;
    tbb[i] = b;
    to[i]  = op;
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(res_valid), 0);
    check({tag, "_data"}, 32'(res_data), 0);
    check({tag, "_zero"}, 32'(res_zero), 0);
    check({tag, "_id"}, 32'(res_id), 0);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_id = 2'(N - 1);
    sb.delete();
  endtask

  // One full transaction from IDLE; exp_win < 0 uses the RR model
  task automatic run_one(input logic [N-1:0] mask, input int exp_win,
                         input int hold);
    int   w;
    exp_t e;
    exp_t got;
    req = mask;
    drive_ops();
    w = (exp_win >= 0) ? exp_win : model_win(mask);
    last_id = 2'(w);
    e.id   = 2'(w);
    e.data = ref_alu(ta[w], tbb[w], to[w]);
    e.zero = (e.data == '0);
    sb.push_back(e);
    if (hold > 0) res_ready = 1'b0;
    tick();
    check("gnt", 32'(gnt), 32'(1) << w);
    check("busy_exec", 32'(busy), 1);
    req = mask & ~(4'b0001 << w);
    ta[w]  = DW'($urandom);
    tbb[w] = DW'($urandom);
    drive_ops();
    tick();
    check("res_valid", 32'(res_valid), 1);
    check("gnt_pulse", 32'(gnt), 0);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      got = '0;
    end else begin
      got = sb.pop_front();
    end
    check("res_data", 32'(res_data), 32'(got.data));
    check("res_zero", 32'(res_zero), 32'(got.zero));
    check("res_id", 32'(res_id), 32'(got.id));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("bp_valid", 32'(res_valid), 1);
      check("bp_data", 32'(res_data), 32'(got.data));
      check("bp_id", 32'(res_id), 32'(got.id));
      check("bp_gnt", 32'(gnt), 0);
    end
    res_ready = 1'b1;
    tick();
    check("accept_valid", 32'(res_valid), 0);
    check("accept_busy", 32'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    res_ready = 1'b1;
    a_bus     = '0;
    b_bus     = '0;
    op_bus    = '0;
    last_id   = 2'(N - 1);
    for (int i = 0; i < N; i++) set_op(i, '0, '0, 2'b00);
    tick();
    tick();
    check_zero_outs("rst");
    rst = 1'b0;

    // Requester 2 alone: 3+5
    set_op(2, 4'd3, 4'd5, 2'b00);
    run_one(4'b0100, 2, 0);

    // SUB on requester 0: zero, then borrow
    set_op(0, 4'd3, 4'd3, 2'b01);
    run_one(4'b0001, 0, 0);
    set_op(0, 4'd2, 4'd3, 2'b01);
    run_one(4'b0001, 0, 0);

    // All four requesting: order 0,1,2,3,0
    do_reset();
    set_op(0, 4'd9, 4'd9, 2'b00);
    set_op(1, 4'd1, 4'd4, 2'b01);
    set_op(2, 4'b1100, 4'b1010, 2'b10);
    set_op(3, 4'b1111, 4'b0101, 2'b11);
    for (int g = 0; g < 5; g++) run_one(4'b1111, g % N, 0);

    // Backpressure with others still requesting
    set_op(1, 4'd7, 4'd8, 2'b00);
    set_op(3, 4'd6, 4'd6, 2'b11);
    run_one(4'b1010, 1, 5);
    run_one(4'b1000, 3, 0);

    // Reset during EXEC
    set_op(1, 4'd5, 4'd5, 2'b00);
    req = 4'b0010;
    drive_ops();
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    check_zero_outs("rst_exec");
    rst = 1'b0;
    last_id = 2'(N - 1);
    sb.delete();

    // Reset during RESP
    req = 4'b0100;
    drive_ops();
    tick();
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    check_zero_outs("rst_resp");
    rst = 1'b0;
    last_id = 2'(N - 1);
    sb.delete();
    set_op(0, 4'd1, 4'd2, 2'b00);
    run_one(4'b1111, 0, 0);

    // Random operations
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < N; i++)
        set_op(i, DW'($urandom), DW'($urandom), 2'($urandom));
      run_one(4'($urandom_range(1, 15)), -1, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
